// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl -- multi-cycle processor control FSM.
//
// Sequences fetch, decode and execution of one instruction at a time and
// produces the datapath strobes for the ALU, PC, IR, memory port and
// register file. Outputs are decoded from the current state. There are four
// exceptions: ir_write and pc_write in FETCH follow mem_ready, illegal in
// DECODE follows the opcode, and pc_write in BRANCH follows alu_zero_flag.
//
// Build option:
//   MCYCLE_CTRL_ADDI_EN  defined   -> opcode 1100 runs as ADDI (ADDI_EX/ADDI_WB)
//                        undefined -> opcode 1100 is reported as illegal
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode              IR opcode field, valid from DECODE onward
//   alu_zero_flag       ALU result == 0
//   mem_ready           memory completion handshake
//   alu_sel             ALU operation (ADD=0111, SUB=1000, R-type = opcode)
//   alu_src_b           ALU B operand: 0 reg, 1 constant 1, 2 sign-ext imm
//   aluout_we           load ALU result register
//   pc_write, pc_src    PC load enable and source: 0 pc+1, 1 branch, 2 jump
//   ir_write            load instruction register
//   mem_req/we/byte     memory request, write, byte qualifier
//   reg_write/reg_dst   register-file write, rd (1) vs rt (0) select
//   mem_to_reg          write back memory data
//   illegal             one-cycle pulse on an undecodable opcode
//
// state    | meaning
// ---------+-------------------------------------------------
// FETCH    | read instruction, increment PC when memory ready
// DECODE   | compute branch target, latch opcode, dispatch
// EXEC_R   | R-type ALU operation
// WB_R     | write R-type result to rd
// ADDR     | compute load/store address
// MEM_RD   | memory read, wait for ready
// WB_MEM   | write load data to rt
// MEM_WR   | memory write, wait for ready
// BRANCH   | compare operands, load branch target if equal
// JUMP     | load jump target
// ADDI_EX  | add immediate (build option only)
// ADDI_WB  | write immediate result to rt (build option only)

module mcycle_ctrl #(
    parameter int op_size = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [op_size-1:0] opcode,
    input  logic               alu_zero_flag,
    input  logic               mem_ready,
    output logic [op_size-1:0] alu_sel,
    output logic [1:0]         alu_src_b,
    output logic               aluout_we,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               ir_write,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_byte,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               illegal
);

    localparam logic [op_size-1:0] OP_LW   = op_size'(1);
    localparam logic [op_size-1:0] OP_LB   = op_size'(2);
    localparam logic [op_size-1:0] OP_SB   = op_size'(4);
    localparam logic [op_size-1:0] OP_AND  = op_size'(5);
    localparam logic [op_size-1:0] OP_SLT  = op_size'(9);
    localparam logic [op_size-1:0] OP_BEQ  = op_size'(10);
    localparam logic [op_size-1:0] OP_J    = op_size'(11);
`ifdef MCYCLE_CTRL_ADDI_EN
    localparam logic [op_size-1:0] OP_ADDI = op_size'(12);
`endif
    localparam logic [op_size-1:0] ALU_ADD = op_size'(7);
    localparam logic [op_size-1:0] ALU_SUB = op_size'(8);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR,
        S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP
`ifdef MCYCLE_CTRL_ADDI_EN
        , S_ADDI_EX, S_ADDI_WB
`endif
    } state_t;

    state_t             state, state_nx;
    logic [op_size-1:0] op_q;
    logic               dec_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            op_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE)
                op_q <= opcode;
        end
    end

    always_comb begin
        state_nx    = state;
        dec_illegal = 1'b0;
        case (state)
            S_FETCH:  if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                if (opcode >= OP_AND && opcode <= OP_SLT)
                    state_nx = S_EXEC_R;
                else if (opcode >= OP_LW && opcode <= OP_SB)
                    state_nx = S_ADDR;
                else if (opcode == OP_BEQ)
                    state_nx = S_BRANCH;
                else if (opcode == OP_J)
                    state_nx = S_JUMP;
`ifdef MCYCLE_CTRL_ADDI_EN
                else if (opcode == OP_ADDI)
                    state_nx = S_ADDI_EX;
`endif
                else begin
                    state_nx    = S_FETCH;
                    dec_illegal = 1'b1;
                end
            end
            S_EXEC_R: state_nx = S_WB_R;
            S_WB_R:   state_nx = S_FETCH;
            // op_q, not opcode: the IR field may already be changing here
            S_ADDR:   state_nx = (op_q == OP_LW || op_q == OP_LB) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem_ready) state_nx = S_WB_MEM;
            S_WB_MEM: state_nx = S_FETCH;
            S_MEM_WR: if (mem_ready) state_nx = S_FETCH;
            S_BRANCH: state_nx = S_FETCH;
            S_JUMP:   state_nx = S_FETCH;
`ifdef MCYCLE_CTRL_ADDI_EN
            S_ADDI_EX: state_nx = S_ADDI_WB;
            S_ADDI_WB: state_nx = S_FETCH;
`endif
            default:  state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        alu_sel    = ALU_ADD;
        alu_src_b  = 2'd0;
        aluout_we  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_byte   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        // Reset silences every strobe at once, without waiting for the
        // state register to settle on a clock edge.
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'd1;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'd2;
                    aluout_we = 1'b1;
                    illegal   = dec_illegal;
                end
                S_EXEC_R: begin
                    alu_sel   = op_q;
                    aluout_we = 1'b1;
                end
                S_WB_R: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_ADDR: begin
                    alu_src_b = 2'd2;
                    aluout_we = 1'b1;
                end
                S_MEM_RD: begin
                    mem_req  = 1'b1;
                    mem_byte = (op_q == OP_LB);
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    mem_byte = (op_q == OP_SB);
                end
                S_BRANCH: begin
                    alu_sel  = ALU_SUB;
                    pc_src   = 2'd1;
                    pc_write = alu_zero_flag;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end
`ifdef MCYCLE_CTRL_ADDI_EN
                S_ADDI_EX: begin
                    alu_src_b = 2'd2;
                    aluout_we = 1'b1;
                end
                S_ADDI_WB: reg_write = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_ctrl.sv
module tb_mcycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opcode;
    logic       alu_zero_flag;
    logic       mem_ready;
    logic [3:0] alu_sel;
    logic [1:0] alu_src_b;
    logic       aluout_we, pc_write, ir_write, mem_req, mem_we, mem_byte;
    logic [1:0] pc_src;
    logic       reg_write, reg_dst, mem_to_reg, illegal;

    int checks   = 0;
    int failures = 0;

    mcycle_ctrl #(.op_size(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .alu_zero_flag (alu_zero_flag),
        .mem_ready     (mem_ready),
        .alu_sel       (alu_sel),
        .alu_src_b     (alu_src_b),
        .aluout_we     (aluout_we),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .ir_write      (ir_write),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_byte      (mem_byte),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    // {alu_sel, alu_src_b, aluout_we, pc_write, pc_src, ir_write, mem_req,
    //  mem_we, mem_byte, reg_write, reg_dst, mem_to_reg, illegal}
    logic [17:0] obs;
    assign obs = {alu_sel, alu_src_b, aluout_we, pc_write, pc_src, ir_write, mem_req,
                  mem_we, mem_byte, reg_write, reg_dst, mem_to_reg, illegal};

    function automatic logic [17:0] v(logic [3:0] sel, logic [1:0] b, logic we, logic pw,
                                      logic [1:0] ps, logic ir, logic mr, logic mw,
                                      logic mb, logic rw, logic rd, logic m2r, logic il);
        return {sel, b, we, pw, ps, ir, mr, mw, mb, rw, rd, m2r, il};
    endfunction

    logic [17:0] rst_v, fetch_wait_v, fetch_go_v, decode_v, wb_r_v, addr_v,
                 wb_mem_v, jump_v, addi_wb_v;

    typedef struct {
        logic       rdy;
        logic       zero;
        logic [3:0] op;
    } stim_t;

    typedef struct {
        string       tag;
        logic [17:0] vec;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%05h exp=%05h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic rdy, input logic zero, input logic [3:0] op,
                        input logic [17:0] vec, input string tag);
        stim_t s;
        exp_t  e;
        s.rdy = rdy; s.zero = zero; s.op = op;
        e.tag = tag; e.vec = vec;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // 0 illegal, 1 R-type, 2 load, 3 store, 4 beq, 5 jump, 6 addi
    function automatic int cls(logic [3:0] op);
        if (op >= 4'd5 && op <= 4'd9) return 1;
        if (op == 4'd1 || op == 4'd2) return 2;
        if (op == 4'd3 || op == 4'd4) return 3;
        if (op == 4'd10) return 4;
        if (op == 4'd11) return 5;
`ifdef MCYCLE_CTRL_ADDI_EN
        if (op == 4'd12) return 6;
`endif
        return 0;
    endfunction

    // op is in the IR for FETCH/DECODE; op_late replaces it afterwards
    task automatic queue_instr(input logic [3:0] op, input logic [3:0] op_late,
                               input int fw, input int mw, input logic zero);
        int   c;
        logic b;
        c = cls(op);
        b = (op == 4'd2) || (op == 4'd4);
        for (int i = 0; i < fw; i++) push(1'b0, 1'b1, op, fetch_wait_v, "fetch_wait");
        push(1'b1, 1'b1, op, fetch_go_v, "fetch_go");
        if (c == 0) begin
            push(1'b1, 1'b1, op, decode_v | 18'h1, "decode_illegal");
            return;
        end
        push(1'b1, 1'b1, op, decode_v, "decode");
        case (c)
            1: begin
                push(1'b1, 1'b1, op_late, v(op, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "exec_r");
                push(1'b1, 1'b1, op_late, wb_r_v, "wb_r");
            end
            2, 3: begin
                push(1'b1, 1'b1, op_late, addr_v, "addr");
                for (int i = 0; i < mw; i++)
                    push(1'b0, 1'b1, op_late,
                         (c == 2) ? v(7, 0, 0, 0, 0, 0, 1, 0, b, 0, 0, 0, 0)
                                  : v(7, 0, 0, 0, 0, 0, 1, 1, b, 0, 0, 0, 0), "mem_wait");
                push(1'b1, 1'b1, op_late,
                     (c == 2) ? v(7, 0, 0, 0, 0, 0, 1, 0, b, 0, 0, 0, 0)
                              : v(7, 0, 0, 0, 0, 0, 1, 1, b, 0, 0, 0, 0), "mem_done");
                if (c == 2) push(1'b1, 1'b1, op_late, wb_mem_v, "wb_mem");
            end
            4: push(1'b1, zero, op_late, v(8, 0, 0, zero, 1, 0, 0, 0, 0, 0, 0, 0, 0), "branch");
            5: push(1'b1, 1'b1, op_late, jump_v, "jump");
            6: begin
                push(1'b1, 1'b1, op_late, addr_v, "addi_ex");
                push(1'b1, 1'b1, op_late, addi_wb_v, "addi_wb");
            end
            default: ;
        endcase
    endtask

    // Called at posedge+1; each entry covers one clock cycle.
    task automatic run_queue();
        stim_t s;
        exp_t  e;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            mem_ready     = s.rdy;
            alu_zero_flag = s.zero;
            opcode        = s.op;
            @(negedge clk);
            e = exp_q.pop_front();
            check(e.tag, obs, e.vec);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_v        = v(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fetch_wait_v = v(7, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        fetch_go_v   = v(7, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        decode_v     = v(7, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb_r_v       = v(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        addr_v       = v(7, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb_mem_v     = v(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        jump_v       = v(7, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        addi_wb_v    = v(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        rst_n = 1'b0; mem_ready = 1'b1; alu_zero_flag = 1'b1; opcode = 4'hf;
        #3;
        check("reset_before_clk", obs, rst_v);
        @(posedge clk); @(posedge clk); #1;
        check("reset_held", obs, rst_v);
        rst_n = 1'b1;

        queue_instr(4'd7, 4'd7, 0, 0, 1'b1);    // ADD
        queue_instr(4'd2, 4'd2, 0, 3, 1'b1);    // LB, three memory waits
        queue_instr(4'd10, 4'd10, 0, 0, 1'b1);  // BEQ taken
        queue_instr(4'd10, 4'd10, 0, 0, 1'b0);  // BEQ not taken
        queue_instr(4'd15, 4'd15, 0, 0, 1'b1);  // illegal
        queue_instr(4'd12, 4'd12, 0, 0, 1'b1);  // ADDI or illegal per build
        queue_instr(4'd3, 4'd6, 0, 0, 1'b1);    // SW, IR changes to OR after decode
        queue_instr(4'd5, 4'd9, 2, 0, 1'b1);    // AND with fetch waits, IR changes
        queue_instr(4'd1, 4'd1, 1, 0, 1'b1);    // LW
        queue_instr(4'd4, 4'd4, 0, 2, 1'b1);    // SB with waits
        queue_instr(4'd11, 4'd11, 0, 0, 1'b0);  // JUMP
        queue_instr(4'd9, 4'd9, 0, 0, 1'b1);    // SLT
        queue_instr(4'd0, 4'd0, 0, 0, 1'b1);    // illegal 0000
        run_queue();

        // Reset while a store is waiting on memory.
        queue_instr(4'd3, 4'd3, 0, 0, 1'b1);
        void'(stim_q.pop_back());
        void'(exp_q.pop_back());
        push(1'b0, 1'b1, 4'd3, v(7, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "mem_wr_wait");
        push(1'b0, 1'b1, 4'd3, v(7, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "mem_wr_wait");
        run_queue();
        mem_ready = 1'b0;
        #2;
        check("pre_reset_mem_wr", obs, v(7, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        #1;
        check("reset_mid_mem_wr", obs, rst_v);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_held", obs, rst_v);
        rst_n = 1'b1;

        queue_instr(4'd8, 4'd8, 1, 0, 1'b1);    // SUB after reset
        push(1'b0, 1'b1, 4'd8, fetch_wait_v, "final_fetch");
        run_queue();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
